// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant lock, programmable hold limit
// and a mandatory dead cycle between owners.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  // One extra bit so MAX_HOLD == 2**CNT_W is representable without wrapping.
  localparam int unsigned HOLD_W = CNT_W + 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  logic [1:0]        state_r;
  logic [1:0]        ptr_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [3:0]        gnt_r;
  logic [1:0]        gnt_idx_r;
  logic              busy_r;
  logic              timeout_r;

  logic [1:0]        state_s;
  logic [1:0]        ptr_s;
  logic [HOLD_W-1:0] hold_cnt_s;
  logic [3:0]        gnt_s;
  logic [1:0]        gnt_idx_s;
  logic              timeout_s;
  logic [1:0]        win_idx_s;
  logic              win_vld_s;
  logic [1:0]        cand_s;

  // Rotating priority search starting at ptr.
  always_comb begin
    win_idx_s = ptr_r;
    win_vld_s = 1'b0;
    cand_s    = ptr_r;
    for (int k = 0; k < 4; k++) begin
      cand_s = ptr_r + 2'(k);
      if (!win_vld_s && req[cand_s]) begin
        win_idx_s = cand_s;
        win_vld_s = 1'b1;
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // Next-state logic for ownership, hold counting and pointer update.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    gnt_s      = gnt_r;
    gnt_idx_s  = gnt_idx_r;
    timeout_s  = 1'b0;
    case (state_r)
      ST_GRANT: begin
        if (!req[gnt_idx_r]) begin
          state_s = ST_GAP;
          gnt_s   = 4'b0000;
          ptr_s   = gnt_idx_r + 2'd1;
        end else if (hold_cnt_r == HOLD_MAX) begin
          state_s   = ST_GAP;
          gnt_s     = 4'b0000;
          ptr_s     = gnt_idx_r + 2'd1;
          timeout_s = 1'b1;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      ST_IDLE, ST_GAP: begin
        if (win_vld_s) begin
          state_s    = ST_GRANT;
          gnt_s      = 4'b0001 << win_idx_s;
          gnt_idx_s  = win_idx_s;
          hold_cnt_s = HOLD_ONE;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = 4'b0000;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 2'd0;
      hold_cnt_r <= {HOLD_W{1'b0}};
      gnt_r      <= 4'b0000;
      gnt_idx_r  <= 2'd0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
      gnt_r      <= gnt_s;
      gnt_idx_r  <= gnt_idx_s;
      busy_r     <= |gnt_s;
      timeout_r  <= timeout_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_idx = gnt_idx_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed, table-driven bench for rr_arbiter4 built with MAX_HOLD=4.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                     input logic t, input int n);
    for (int k = 0; k < n; k++) vecs.push_back('{req: r, gnt: g, idx: i, to: t});
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;

    // single request, released before hold limit
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1);
    add(4'b0100, 4'b0100, 2'd2, 1'b0, 3);
    add(4'b0000, 4'b0000, 2'd2, 1'b0, 2);
    // rotation with all requesting (ptr=3 here): 3,0,1,2,3
    add(4'b1111, 4'b1000, 2'd3, 1'b0, 3);
    add(4'b0111, 4'b0000, 2'd3, 1'b0, 1);
    add(4'b1111, 4'b0001, 2'd0, 1'b0, 3);
    add(4'b1110, 4'b0000, 2'd0, 1'b0, 1);
    add(4'b1111, 4'b0010, 2'd1, 1'b0, 3);
    add(4'b1101, 4'b0000, 2'd1, 1'b0, 1);
    add(4'b1111, 4'b0100, 2'd2, 1'b0, 3);
    add(4'b1011, 4'b0000, 2'd2, 1'b0, 1);
    add(4'b1111, 4'b1000, 2'd3, 1'b0, 1);
    add(4'b0000, 4'b0000, 2'd3, 1'b0, 1);
    // owner 2 drops on the same edge req[3] rises
    add(4'b0100, 4'b0100, 2'd2, 1'b0, 1);
    add(4'b1000, 4'b0000, 2'd2, 1'b0, 1);
    add(4'b1000, 4'b1000, 2'd3, 1'b0, 1);
    add(4'b0000, 4'b0000, 2'd3, 1'b0, 2);
    // lone requester times out and is re-granted after the gap
    add(4'b0010, 4'b0010, 2'd1, 1'b0, 4);
    add(4'b0010, 4'b0000, 2'd1, 1'b1, 1);
    add(4'b0010, 4'b0010, 2'd1, 1'b0, 4);
    add(4'b0010, 4'b0000, 2'd1, 1'b1, 1);
    add(4'b0000, 4'b0000, 2'd1, 1'b0, 1);
    // two continuous requesters alternate on timeout (ptr=2 here)
    add(4'b0011, 4'b0001, 2'd0, 1'b0, 4);
    add(4'b0011, 4'b0000, 2'd0, 1'b1, 1);
    add(4'b0011, 4'b0010, 2'd1, 1'b0, 4);
    add(4'b0011, 4'b0000, 2'd1, 1'b1, 1);
    add(4'b0011, 4'b0001, 2'd0, 1'b0, 4);
    add(4'b0011, 4'b0000, 2'd0, 1'b1, 1);
    add(4'b0000, 4'b0000, 2'd0, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset gnt", {4'b0000, gnt}, 8'h00);
    check("reset idx", {6'b000000, gnt_idx}, 8'h00);
    check("reset busy", {7'b0000000, busy}, 8'h00);
    check("reset timeout", {7'b0000000, timeout}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("v%0d gnt", i), {4'b0000, gnt}, {4'b0000, vecs[i].gnt});
      check($sformatf("v%0d idx", i), {6'b000000, gnt_idx}, {6'b000000, vecs[i].idx});
      check($sformatf("v%0d busy", i), {7'b0000000, busy}, {7'b0000000, |vecs[i].gnt});
      check($sformatf("v%0d timeout", i), {7'b0000000, timeout}, {7'b0000000, vecs[i].to});
    end

    // asynchronous reset while client 0 owns the grant (ptr=1 here)
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk);
    #1;
    check("pre-reset gnt", {4'b0000, gnt}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset gnt", {4'b0000, gnt}, 8'h00);
    check("async reset busy", {7'b0000000, busy}, 8'h00);
    check("async reset idx", {6'b000000, gnt_idx}, 8'h00);
    @(negedge clk);
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset gnt", {4'b0000, gnt}, 8'h02);
    check("post-reset idx", {6'b000000, gnt_idx}, 8'h01);
    check("post-reset busy", {7'b0000000, busy}, 8'h01);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("post-reset release", {4'b0000, gnt}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
